// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder
// SPI mode-0 slave standing in for the ADXL362 accelerometer. The SPI pins are
// oversampled on ClkPort, and register reads/writes are served from a small
// register map. Injected X/Y/Z samples are snapshotted at the start of each
// frame, so a burst read always returns one coherent sample.

module adxl362_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  input  logic [11:0] accel_z,
  input  logic        sample_valid,
  output logic        reg_wr_en,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic       sclk_prev;
  logic       ss_prev;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       ss_fall;
  logic       ss_rise;
  logic       mosi_d;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [5:0] addr;
  logic       is_read;
  logic       data_ready;
  logic [11:0] shadow_x;
  logic [11:0] shadow_y;
  logic [11:0] shadow_z;
  logic [7:0] storage [16];

  logic [7:0] rx_byte;
  logic       byte_done;
  logic [5:0] next_addr;
  logic [5:0] load_addr;
  logic [3:0] rd_idx;
  logic [3:0] wr_idx;
  logic       load_tx;
  logic       clear_ready;
  logic       addr_writable;
  logic [7:0] load_data;

  // Synchronize the SPI pins and register one-cycle edge pulses; the ss chain
  // resets low so a reset taken mid-frame cannot invent a fresh ss fall.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      mosi_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      ss_prev   <= ss_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_prev;
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_prev;
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Byte assembly, address stepping and the register-map read mux.
  always_comb begin
    rx_byte       = {rx_shift[6:0], mosi_d};
    byte_done     = sclk_rise && (bit_cnt == 3'd7);
    next_addr     = addr + 6'd1;
    load_addr     = (state == ADDR) ? rx_byte[5:0] : next_addr;
    rd_idx        = load_addr[3:0] - 4'hF;
    wr_idx        = addr[3:0] - 4'hF;
    load_tx       = byte_done && is_read && ((state == ADDR) || (state == DATA));
    clear_ready   = load_tx &&
                    (((load_addr >= 6'h08) && (load_addr <= 6'h0A)) ||
                     ((load_addr >= 6'h0E) && (load_addr <= 6'h13)));
    addr_writable = (addr >= 6'h1F) && (addr <= 6'h2E);
    load_data     = 8'h00;
    case (load_addr)
      6'h00: load_data = 8'hAD;
      6'h01: load_data = 8'h1D;
      6'h02: load_data = 8'hF2;
      6'h03: load_data = 8'h01;
      6'h08: load_data = shadow_x[11:4];
      6'h09: load_data = shadow_y[11:4];
      6'h0A: load_data = shadow_z[11:4];
      6'h0B: load_data = {7'd0, data_ready};
      6'h0E: load_data = shadow_x[7:0];
      6'h0F: load_data = {{4{shadow_x[11]}}, shadow_x[11:8]};
      6'h10: load_data = shadow_y[7:0];
      6'h11: load_data = {{4{shadow_y[11]}}, shadow_y[11:8]};
      6'h12: load_data = shadow_z[7:0];
      6'h13: load_data = {{4{shadow_z[11]}}, shadow_z[11:8]};
      default: begin
        if ((load_addr >= 6'h1F) && (load_addr <= 6'h2E)) begin
          load_data = storage[rd_idx];
        end
      end
    endcase
  end

  // Transaction state machine with registered miso, write strobe and error pulse.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      addr        <= 6'd0;
      is_read     <= 1'b0;
      data_ready  <= 1'b0;
      shadow_x    <= 12'd0;
      shadow_y    <= 12'd0;
      shadow_z    <= 12'd0;
      miso        <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= 6'd0;
      reg_wr_data <= 8'h00;
      cmd_err     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        storage[i] <= (i == 13) ? 8'h13 : 8'h00;
      end
    end else begin
      reg_wr_en <= 1'b0;
      cmd_err   <= 1'b0;

      if (sample_valid) begin
        data_ready <= 1'b1;
      end else if (clear_ready) begin
        data_ready <= 1'b0;
      end

      if (sclk_rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (ss_rise) begin
        state <= IDLE;
        miso  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (ss_fall) begin
              state    <= CMD;
              bit_cnt  <= 3'd0;
              shadow_x <= accel_x;
              shadow_y <= accel_y;
              shadow_z <= accel_z;
            end
          end
          CMD: begin
            miso <= 1'b0;
            if (byte_done) begin
              if (rx_byte == 8'h0B) begin
                is_read <= 1'b1;
                state   <= ADDR;
              end else if (rx_byte == 8'h0A) begin
                is_read <= 1'b0;
                state   <= ADDR;
              end else begin
                cmd_err <= 1'b1;
                state   <= IGNORE;
              end
            end
          end
          ADDR: begin
            miso <= 1'b0;
            if (byte_done) begin
              addr <= rx_byte[5:0];
              if (is_read) begin
                tx_shift <= load_data;
              end
              state <= DATA;
            end
          end
          DATA: begin
            if (is_read) begin
              if (sclk_fall) begin
                miso     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
              if (byte_done) begin
                addr     <= next_addr;
                tx_shift <= load_data;
              end
            end else begin
              miso <= 1'b0;
              if (byte_done) begin
                if (addr_writable) begin
                  storage[wr_idx] <= rx_byte;
                end
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= addr;
                reg_wr_data <= rx_byte;
                addr        <= next_addr;
              end
            end
          end
          IGNORE: begin
            miso <= 1'b0;
          end
          default: begin
            miso  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
